// File: rtl/cam_axis_crop_pkg.sv
// Shared camera stream definitions: counter width default, crop FSM states
// and byte-lane offsets of the packed R-B-G pixel.
package cam_axis_crop_pkg;

  localparam int CAM_CNT_WIDTH  = 12;
  localparam int CAM_DATA_WIDTH = 24;

  localparam int CAM_R_LSB = 0;
  localparam int CAM_B_LSB = 8;
  localparam int CAM_G_LSB = 16;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } crop_state_t;

endpackage

// File: rtl/cam_axis_crop_reg_slice.sv
// Single-stage AXI4-Stream output register; frame_done is qualified by the
// actual output handshake so it pulses exactly when the flagged beat transfers.
module cam_axis_reg_slice #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_user,
  input  logic                  in_frame_end,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_done
);

  logic frame_end_q;

  assign s_ready    = m_axis_tready | ~m_axis_tvalid;
  assign frame_done = m_axis_tvalid & m_axis_tready & frame_end_q;

  // load is only raised on an accepted beat, so the slot is free or draining here
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      frame_end_q   <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= in_data;
      m_axis_tlast  <= in_last;
      m_axis_tuser  <= in_user;
      frame_end_q   <= in_frame_end;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_axis_crop.sv
// Crops a rectangular window out of an AXI4-Stream video frame; x/y counters
// and the SOF-tracking FSM live here, the output register in cam_axis_reg_slice.
module cam_axis_crop
  import cam_axis_crop_pkg::*;
#(
  parameter int DATA_WIDTH = CAM_DATA_WIDTH,
  parameter int CNT_WIDTH  = CAM_CNT_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic [CNT_WIDTH-1:0]  crop_x,
  input  logic [CNT_WIDTH-1:0]  crop_y,
  input  logic [CNT_WIDTH-1:0]  crop_w,
  input  logic [CNT_WIDTH-1:0]  crop_h,
  output logic                  frame_done,
  output logic                  short_line
);

  localparam int SW = CNT_WIDTH + 1;

  crop_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [CNT_WIDTH-1:0] cx_q, cy_q, cw_q, ch_q;
  logic [CNT_WIDTH-1:0] cx, cy, cw, ch, px, py;
  logic                 first_q, first_d, short_q, short_d;
  logic                 s_ready, accept, sof, process, fwd, in_h, in_v;
  logic                 out_last, first_eff, frame_end;
  logic [SW-1:0]        x_end, y_end, px_next, py_next;

  assign s_axis_tready = s_ready;
  assign short_line    = short_q;

  assign accept  = s_axis_tvalid & s_ready;
  assign sof     = accept & s_axis_tuser;
  assign process = accept & (sof | (state_q == ACTIVE));

  // The SOF beat itself must already be cropped with the configuration it latches
  assign cx = sof ? crop_x : cx_q;
  assign cy = sof ? crop_y : cy_q;
  assign cw = sof ? crop_w : cw_q;
  assign ch = sof ? crop_h : ch_q;
  assign px = sof ? '0 : x_q;
  assign py = sof ? '0 : y_q;

  assign x_end   = {1'b0, cx} + {1'b0, cw};
  assign y_end   = {1'b0, cy} + {1'b0, ch};
  assign px_next = {1'b0, px} + SW'(1);
  assign py_next = {1'b0, py} + SW'(1);

  assign in_h      = ({1'b0, px} >= {1'b0, cx}) && ({1'b0, px} < x_end);
  assign in_v      = ({1'b0, py} >= {1'b0, cy}) && ({1'b0, py} < y_end);
  assign fwd       = process & in_h & in_v;
  assign out_last  = (px_next == x_end) | s_axis_tlast;
  assign first_eff = sof | first_q;
  assign frame_end = out_last & (py_next == y_end);
  assign short_d   = process & in_v & s_axis_tlast & (px_next < x_end);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    first_d = first_q;
    if (process) begin
      state_d = ACTIVE;
      first_d = first_eff & ~fwd;
      if (s_axis_tlast) begin
        x_d = '0;
        y_d = py_next[CNT_WIDTH-1:0];
        if (py_next >= y_end) begin
          state_d = WAIT_SOF;
        end
      end else begin
        x_d = px_next[CNT_WIDTH-1:0];
        y_d = py;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      cw_q    <= '0;
      ch_q    <= '0;
      first_q <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      first_q <= first_d;
      short_q <= short_d;
      if (sof) begin
        cx_q <= crop_x;
        cy_q <= crop_y;
        cw_q <= crop_w;
        ch_q <= crop_h;
      end
    end
  end

  cam_axis_reg_slice #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .load         (fwd),
    .in_data      (s_axis_tdata),
    .in_last      (out_last),
    .in_user      (first_eff),
    .in_frame_end (frame_end),
    .s_ready      (s_ready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_done   (frame_done)
  );

endmodule
